vliw_wb_arbiter: RTL and testbench
==================================

// Module: vliw_wb_arbiter
// PURPOSE
// Writeback-port scheduler between NLANES IEU lanes and the shared, widened integer regfile.
// - Each lane presents one Writeback-stage result per bundle; the regfile has only NWP write ports.
// - Grants lanes round-robin and coalesces same-bundle WAW writes (youngest lane wins).
// - Stalls the W stage until every lane of the bundle is written.
// - Exports a busy-register mask so the hazard unit stalls Decode reads of pending destinations.
// PARAMETERS
// XLEN    64  datapath width
// NLANES  4   issue lanes; lane 0 is oldest in bundle order
// NWP     2   regfile write ports, 1 <= NWP <= NLANES
// PORTS
// clk       in   1            clock
// reset     in   1            reset; asynchronous, active-low (asserted when 0)
// ReqValid  in   NLANES       lane i holds a result (RegWriteW of lane i)
// ReqRd     in   NLANES*5     lane i destination register, lane i at [5i+4:5i]
// ReqData   in   NLANES*XLEN  lane i result, lane i at [XLEN*i+XLEN-1:XLEN*i]
// ReqAck    out  NLANES       lane i accepted this cycle (combinational pulse)
// WBStall   out  1            bundle incomplete; hold W stage and all Req* inputs stable
// WE        out  NWP          regfile port k write enable (registered)
// WA        out  NWP*5        regfile port k address (registered)
// WD        out  NWP*XLEN     regfile port k data (registered)
// BusyRegs  out  32           bit r set: write to xr pending or in flight; bit 0 always 0
// BEHAVIOUR
// State: Ptr (log2 NLANES bits, round-robin start), DoneMask (NLANES), WE/WA/WD registers.
// Reset (async, reset==0):
// - Ptr=0, DoneMask=0, WE=0, WA=0, WD=0, independent of clk.
// - Combinational outputs then follow inputs with DoneMask=0.
// Pending(i) = ReqValid[i] & ~DoneMask[i].
// Superseded(i) = Pending(i) & exists j>i with Pending(j) & ReqRd[j]==ReqRd[i] & ReqRd[i]!=0.
// Trivial(i) = Pending(i) & ReqRd[i]==0.
// Superseded and trivial lanes are acked this cycle without using a port.
// Eligible(i) = Pending(i) & ~Superseded(i) & ~Trivial(i).
// Grant:
// - Scan lanes Ptr, Ptr+1, ... mod NLANES.
// - The first NWP eligible lanes are granted; the k-th granted lane in scan order drives port k.
// ReqAck[i] = Trivial | Superseded | Granted, combinational.
// WBStall = OR over lanes of (Pending & ~ReqAck), combinational.
// Write latency: 1 cycle. Grants at edge N appear on WE/WA/WD after edge N; unused ports WE=0.
// - WA/WD hold their previous value when WE=0.
// Ptr: if any lane granted, Ptr <= (last granted lane in scan order + 1) mod NLANES; else unchanged.
// DoneMask:
// - If WBStall=1, DoneMask <= DoneMask | ReqAck.
// - If WBStall=0, DoneMask <= 0; the bundle completes and new inputs may arrive next cycle.
// BusyRegs:
// - Set ReqRd[i] for each Pending(i) lane that is not acked this cycle.
// - Set WA[k] for each WE[k]=1.
// - Bit 0 forced to 0.
// Boundaries:
// - All lanes idle: no acks, WBStall=0, WE=0 next cycle, Ptr held.
// - Two lanes write the same rd: only the youngest is written; the older is acked and never written.
// - Ptr wrap: lane NLANES-1 granted last -> Ptr=0.
// - Reset mid-bundle: DoneMask cleared, the in-flight write is dropped (WE=0).
// - A bundle never needs more than ceil(NLANES/NWP) cycles.
// TESTING
// 1 Reset: hold reset=0 with all lanes valid.
//   -> WE=0, Ptr=0, DoneMask=0 regardless of clk; after release, the normal grant sequence starts at lane 0.
// 2 Lanes 0,1 valid, rd 5,6, Ptr=0.
//   -> ReqAck=0011, WBStall=0; next cycle WE=11, WA0=5, WA1=6; Ptr=2.
// 3 Four lanes valid, rd 1,2,3,4, Ptr=0.
//   -> cycle0: ack 0,1, WBStall=1, BusyRegs bits 3,4 set.
//   -> cycle1: ack 2,3, WBStall=0; writes x1,x2 then x3,x4; Ptr=0.
// 4 Lane0 rd7 data A, lane1 rd8 data C, lane2 rd7 data B, Ptr=0.
//   -> all acked in 1 cycle; port0 x8=C, port1 x7=B; A never written.
// 5 Lanes 0-3 valid, all rd=0.
//   -> ReqAck=1111, WBStall=0, WE=00 next cycle, Ptr unchanged.
// 6 Reset=0 mid-bundle (lanes 2,3 pending, WE=11).
//   -> WE=00, DoneMask=0 immediately; BusyRegs shows only the rds of currently valid lanes.

Source files
------------

// File: rtl/vliw_wb_arbiter.sv
// Writeback-port scheduler: funnels NLANES per-bundle lane results into NWP regfile
// write ports with round-robin grants, same-bundle WAW coalescing and a busy-register mask.
module vliw_wb_arbiter #(
   parameter int XLEN   = 64,
   parameter int NLANES = 4,
   parameter int NWP    = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NLANES-1:0]      ReqValid,
   input  logic [NLANES*5-1:0]    ReqRd,
   input  logic [NLANES*XLEN-1:0] ReqData,
   output logic [NLANES-1:0]      ReqAck,
   output logic                   WBStall,
   output logic [NWP-1:0]         WE,
   output logic [NWP*5-1:0]       WA,
   output logic [NWP*XLEN-1:0]    WD,
   output logic [31:0]            BusyRegs
);
   localparam int PW = (NLANES > 1) ? $clog2(NLANES) : 1;

   logic [PW-1:0]     ptr;
   logic [PW-1:0]     ptrNext;
   logic [NLANES-1:0] doneMask;
   logic [NLANES-1:0] pending;
   logic [NLANES-1:0] superseded;
   logic [NLANES-1:0] trivial;
   logic [NLANES-1:0] eligible;
   logic [NLANES-1:0] granted;
   logic [NWP-1:0]    portValid;
   logic [PW-1:0]     portLane [NWP];

   // A lane is superseded when a younger pending lane of the same bundle targets the same rd.
   // NOTE: every combinational output gets a default before the loops so no latch is inferred.
   always_comb begin
      pending    = ReqValid & ~doneMask;
      superseded = '0;
      trivial    = '0;
      for (int i = 0; i < NLANES; i++) begin
         trivial[i] = pending[i] && (ReqRd[5*i +: 5] == 5'd0);
         for (int j = i + 1; j < NLANES; j++) begin
            if (pending[i] && pending[j] && (ReqRd[5*j +: 5] == ReqRd[5*i +: 5]) &&
                (ReqRd[5*i +: 5] != 5'd0))
               superseded[i] = 1'b1;
         end
      end
      eligible = pending & ~superseded & ~trivial;
   end

   // Scan lanes starting at ptr; the k-th eligible lane found drives port k.
   always_comb begin
      logic [PW:0] sum;
      int          cnt;
      sum       = '0;
      cnt       = 0;
      granted   = '0;
      portValid = '0;
      ptrNext   = ptr;
      for (int k = 0; k < NWP; k++) portLane[k] = '0;
      for (int s = 0; s < NLANES; s++) begin
         sum = {1'b0, ptr} + (PW+1)'(s);
         if (sum >= (PW+1)'(NLANES)) sum = sum - (PW+1)'(NLANES);
         for (int i = 0; i < NLANES; i++) begin
            if ((sum[PW-1:0] == PW'(i)) && eligible[i] && (cnt < NWP)) begin
               granted[i] = 1'b1;
               for (int k = 0; k < NWP; k++) begin
                  if (k == cnt) begin
                     portValid[k] = 1'b1;
                     portLane[k]  = PW'(i);
                  end
               end
               cnt++;
               ptrNext = (i == NLANES - 1) ? '0 : PW'(i + 1);
            end
         end
      end
   end

   assign ReqAck  = trivial | superseded | granted;
   assign WBStall = |(pending & ~ReqAck);

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   // NOTE: WA/WD are reset too, so a write in flight at reset is dropped with a known address.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr      <= '0;
         doneMask <= '0;
         WE       <= '0;
         WA       <= '0;
         WD       <= '0;
      end else begin
         ptr      <= ptrNext;
         doneMask <= WBStall ? (doneMask | ReqAck) : '0;
         for (int k = 0; k < NWP; k++) begin
            WE[k] <= portValid[k];
            for (int i = 0; i < NLANES; i++) begin
               if (portValid[k] && (portLane[k] == PW'(i))) begin
                  WA[5*k +: 5]       <= ReqRd[5*i +: 5];
                  WD[XLEN*k +: XLEN] <= ReqData[XLEN*i +: XLEN];
               end
            end
         end
      end
   end

   // Busy = destinations still waiting for a port plus writes landing this cycle.
   always_comb begin
      BusyRegs = '0;
      for (int i = 0; i < NLANES; i++)
         if (pending[i] && !ReqAck[i]) BusyRegs[ReqRd[5*i +: 5]] = 1'b1;
      for (int k = 0; k < NWP; k++)
         if (WE[k]) BusyRegs[WA[5*k +: 5]] = 1'b1;
      BusyRegs[0] = 1'b0;
   end
endmodule

// File: tb/tb_vliw_wb_arbiter.sv
// Directed bench for vliw_wb_arbiter (4 lanes, 2 write ports): reset, grants, coalescing,
// trivial writes, pointer wrap and reset in the middle of a bundle.
module tb_vliw_wb_arbiter;
   localparam int XLEN   = 64;
   localparam int NLANES = 4;
   localparam int NWP    = 2;

   localparam logic [63:0] D1 = 64'h1111_0000_0000_0001;
   localparam logic [63:0] D2 = 64'h2222_0000_0000_0002;
   localparam logic [63:0] D3 = 64'h3333_0000_0000_0003;
   localparam logic [63:0] D4 = 64'h4444_0000_0000_0004;
   localparam logic [63:0] DA = 64'hAAAA_0000_0000_000A;
   localparam logic [63:0] DB = 64'hBBBB_0000_0000_000B;
   localparam logic [63:0] DC = 64'hCCCC_0000_0000_000C;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [NLANES-1:0]      ReqValid;
   logic [NLANES*5-1:0]    ReqRd;
   logic [NLANES*XLEN-1:0] ReqData;
   logic [NLANES-1:0]      ReqAck;
   logic                   WBStall;
   logic [NWP-1:0]         WE;
   logic [NWP*5-1:0]       WA;
   logic [NWP*XLEN-1:0]    WD;
   logic [31:0]            BusyRegs;

   int total = 0;
   int bad   = 0;

   vliw_wb_arbiter #(.XLEN(XLEN), .NLANES(NLANES), .NWP(NWP)) dut (
      .clk(clk), .reset(reset), .ReqValid(ReqValid), .ReqRd(ReqRd), .ReqData(ReqData),
      .ReqAck(ReqAck), .WBStall(WBStall), .WE(WE), .WA(WA), .WD(WD), .BusyRegs(BusyRegs)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset held with a full bundle presented.
      reset    = 1'b0;
      ReqValid = 4'b1111;
      ReqRd    = {5'd4, 5'd3, 5'd2, 5'd1};
      ReqData  = {D4, D3, D2, D1};
      #1;
      check("rst_we_noclk", 64'(WE), 64'd0);
      check("rst_ptr_noclk", 64'(dut.ptr), 64'd0);
      check("rst_done_noclk", 64'(dut.doneMask), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_we_clk", 64'(WE), 64'd0);
      check("rst_ptr_clk", 64'(dut.ptr), 64'd0);
      check("rst_done_clk", 64'(dut.doneMask), 64'd0);
      check("rst_ack", 64'(ReqAck), 64'b0011);
      check("rst_stall", 64'(WBStall), 64'd1);

      // Four-lane bundle after release: two cycles, lanes 0,1 then 2,3.
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("b4_c0_ack", 64'(ReqAck), 64'b0011);
      check("b4_c0_stall", 64'(WBStall), 64'd1);
      check("b4_c0_busy", 64'(BusyRegs), 64'h18);
      @(posedge clk);
      #1;
      check("b4_c0_we", 64'(WE), 64'b11);
      check("b4_c0_wa0", 64'(WA[4:0]), 64'd1);
      check("b4_c0_wa1", 64'(WA[9:5]), 64'd2);
      check("b4_c0_wd0", WD[63:0], D1);
      check("b4_c0_wd1", WD[127:64], D2);
      check("b4_c0_ptr", 64'(dut.ptr), 64'd2);
      check("b4_c1_ack", 64'(ReqAck), 64'b1100);
      check("b4_c1_stall", 64'(WBStall), 64'd0);
      check("b4_c1_busy", 64'(BusyRegs), 64'h6);
      @(posedge clk);
      #1;
      check("b4_c1_we", 64'(WE), 64'b11);
      check("b4_c1_wa0", 64'(WA[4:0]), 64'd3);
      check("b4_c1_wa1", 64'(WA[9:5]), 64'd4);
      check("b4_c1_wd0", WD[63:0], D3);
      check("b4_c1_wd1", WD[127:64], D4);
      check("b4_c1_ptr", 64'(dut.ptr), 64'd0);
      check("b4_c1_done", 64'(dut.doneMask), 64'd0);

      // Lanes 0,1 -> x5,x6 in a single cycle.
      @(negedge clk);
      ReqValid = 4'b0011;
      ReqRd    = {5'd0, 5'd0, 5'd6, 5'd5};
      #1;
      check("b2_ack", 64'(ReqAck), 64'b0011);
      check("b2_stall", 64'(WBStall), 64'd0);
      check("b2_busy", 64'(BusyRegs), 64'h18);
      @(posedge clk);
      #1;
      check("b2_we", 64'(WE), 64'b11);
      check("b2_wa0", 64'(WA[4:0]), 64'd5);
      check("b2_wa1", 64'(WA[9:5]), 64'd6);
      check("b2_ptr", 64'(dut.ptr), 64'd2);

      // All four lanes target x0: acked, nothing written, Ptr held.
      @(negedge clk);
      ReqValid = 4'b1111;
      ReqRd    = '0;
      #1;
      check("x0_ack", 64'(ReqAck), 64'b1111);
      check("x0_stall", 64'(WBStall), 64'd0);
      @(posedge clk);
      #1;
      check("x0_we", 64'(WE), 64'b00);
      check("x0_ptr", 64'(dut.ptr), 64'd2);
      check("x0_wa_hold", 64'(WA), 64'((6 << 5) | 5));
      check("x0_busy", 64'(BusyRegs), 64'd0);

      // Idle lanes.
      @(negedge clk);
      ReqValid = 4'b0000;
      #1;
      check("idle_ack", 64'(ReqAck), 64'd0);
      check("idle_stall", 64'(WBStall), 64'd0);
      @(posedge clk);
      #1;
      check("idle_we", 64'(WE), 64'b00);
      check("idle_ptr", 64'(dut.ptr), 64'd2);

      // Lanes 2,3 granted from Ptr=2: last grant is lane 3, Ptr wraps to 0.
      @(negedge clk);
      ReqValid = 4'b1100;
      ReqRd    = {5'd10, 5'd9, 5'd0, 5'd0};
      #1;
      check("wrap_ack", 64'(ReqAck), 64'b1100);
      @(posedge clk);
      #1;
      check("wrap_wa0", 64'(WA[4:0]), 64'd9);
      check("wrap_wa1", 64'(WA[9:5]), 64'd10);
      check("wrap_ptr", 64'(dut.ptr), 64'd0);

      // WAW: lane0 x7=A superseded by lane2 x7=B; lane1 x8=C.
      @(negedge clk);
      ReqValid = 4'b0111;
      ReqRd    = {5'd0, 5'd7, 5'd8, 5'd7};
      ReqData  = {64'd0, DB, DC, DA};
      #1;
      check("waw_ack", 64'(ReqAck), 64'b0111);
      check("waw_stall", 64'(WBStall), 64'd0);
      @(posedge clk);
      #1;
      check("waw_we", 64'(WE), 64'b11);
      check("waw_wa0", 64'(WA[4:0]), 64'd8);
      check("waw_wd0", WD[63:0], DC);
      check("waw_wa1", 64'(WA[9:5]), 64'd7);
      check("waw_wd1", WD[127:64], DB);
      check("waw_ptr", 64'(dut.ptr), 64'd3);

      // Single lane 3 write brings Ptr back to 0.
      @(negedge clk);
      ReqValid = 4'b1000;
      ReqRd    = {5'd20, 15'd0};
      #1;
      check("l3_ack", 64'(ReqAck), 64'b1000);
      @(posedge clk);
      #1;
      check("l3_we", 64'(WE), 64'b01);
      check("l3_wa0", 64'(WA[4:0]), 64'd20);
      check("l3_ptr", 64'(dut.ptr), 64'd0);

      // Reset mid-bundle with lanes 2,3 pending and both ports in flight.
      @(negedge clk);
      ReqValid = 4'b1111;
      ReqRd    = {5'd14, 5'd13, 5'd12, 5'd11};
      ReqData  = {D4, D3, D2, D1};
      #1;
      check("mid_c0_ack", 64'(ReqAck), 64'b0011);
      check("mid_c0_stall", 64'(WBStall), 64'd1);
      @(posedge clk);
      #1;
      check("mid_we_pre", 64'(WE), 64'b11);
      check("mid_done_pre", 64'(dut.doneMask), 64'b0011);
      reset = 1'b0;
      #1;
      check("mid_we_rst", 64'(WE), 64'b00);
      check("mid_wa_rst", 64'(WA), 64'd0);
      check("mid_done_rst", 64'(dut.doneMask), 64'd0);
      check("mid_ptr_rst", 64'(dut.ptr), 64'd0);
      check("mid_ack_rst", 64'(ReqAck), 64'b0011);
      check("mid_busy_rst", 64'(BusyRegs), 64'h6000);
      @(posedge clk);
      #1;
      check("mid_we_hold", 64'(WE), 64'b00);
      check("mid_done_hold", 64'(dut.doneMask), 64'd0);
      @(negedge clk);
      reset    = 1'b1;
      ReqValid = 4'b0000;
      @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
